// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate-kind encoding and buffer states for the
// pipelined immediate generator.
package imm_gen_pkg;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_BGZ   = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_BLZ   = 4'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADI   = 4'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 4'd5;
    localparam logic [OPCODE_WIDTH-1:0] OP_LHI   = 4'd6;
    localparam logic [OPCODE_WIDTH-1:0] OP_LWD   = 4'd7;
    localparam logic [OPCODE_WIDTH-1:0] OP_SWD   = 4'd8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 4'd9;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 4'd10;
    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 4'd15;

    typedef enum logic [2:0] {
        IMM_SEXT = 3'd0,
        IMM_ZEXT = 3'd1,
        IMM_LHI  = 3'd2,
        IMM_JTGT = 3'd3,
        IMM_NONE = 3'd4
    } imm_kind_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Conditional branches BNE..BLZ get a PC-relative target.
    function automatic logic is_branch(input logic [OPCODE_WIDTH-1:0] opcode);
        return opcode <= OP_BLZ;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between the fetch side and the immediate generator.
// Carries out_btarget only when IMM_BRANCH_TARGET_EN is defined.
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [DATA_WIDTH-1:0]  in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_imm;
    imm_kind_t              out_kind;
    logic [DATA_WIDTH-1:0]  out_pc;
`ifdef IMM_BRANCH_TARGET_EN
    logic [DATA_WIDTH-1:0]  out_btarget;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_kind, out_pc, out_btarget
    );
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_kind, out_pc, out_btarget
    );
`else
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_kind, out_pc
    );
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_kind, out_pc
    );
`endif
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode decode and immediate extension.
// With IMM_BRANCH_TARGET_EN defined it also forms pc + 1 + imm for branches.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int INSTR_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 8,
    parameter int TARGET_WIDTH = 12
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  pc,
    output logic [DATA_WIDTH-1:0]  imm,
    output imm_kind_t              kind
`ifdef IMM_BRANCH_TARGET_EN
    ,output logic [DATA_WIDTH-1:0] btarget
`endif
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [TARGET_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0]   sext_val;
    logic [DATA_WIDTH-1:0]   zext_val;
    logic [DATA_WIDTH-1:0]   lhi_val;
    logic [DATA_WIDTH-1:0]   jtgt_val;

    assign opcode   = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign offset   = instr[OFFSET_WIDTH-1:0];
    assign target   = instr[TARGET_WIDTH-1:0];

    assign sext_val = DATA_WIDTH'($signed(offset));
    assign zext_val = DATA_WIDTH'(offset);
    assign lhi_val  = zext_val << OFFSET_WIDTH;
    // Keep the PC's page bits and replace the low TARGET_WIDTH bits.
    assign jtgt_val = ((pc >> TARGET_WIDTH) << TARGET_WIDTH) | DATA_WIDTH'(target);

    always_comb begin
        imm  = '0;
        kind = IMM_NONE;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ, OP_ADI, OP_LWD, OP_SWD: begin
                imm  = sext_val;
                kind = IMM_SEXT;
            end
            OP_ORI: begin
                imm  = zext_val;
                kind = IMM_ZEXT;
            end
            OP_LHI: begin
                imm  = lhi_val;
                kind = IMM_LHI;
            end
            OP_JMP, OP_JAL: begin
                imm  = jtgt_val;
                kind = IMM_JTGT;
            end
            default: begin
                imm  = '0;
                kind = IMM_NONE;
            end
        endcase
    end

`ifdef IMM_BRANCH_TARGET_EN
    assign btarget = is_branch(opcode) ? (pc + DATA_WIDTH'(1) + sext_val) : '0;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode ahead of a registered output stage
// with a one-entry skid buffer. Optional IMM_BRANCH_TARGET_EN adds out_btarget.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int INSTR_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 8,
    parameter int TARGET_WIDTH = 12
) (
    input  logic           clk,
    input  logic           reset,
    imm_gen_pipe_if.slave  bus
);
    logic [DATA_WIDTH-1:0] dec_imm;
    imm_kind_t             dec_kind;

    buf_state_t            state_reg, state_next;
    logic                  out_valid_reg, in_ready_reg;
    logic [DATA_WIDTH-1:0] out_imm_reg, out_pc_reg;
    imm_kind_t             out_kind_reg;
    logic [DATA_WIDTH-1:0] skid_imm_reg, skid_pc_reg;
    imm_kind_t             skid_kind_reg;

    logic in_fire;
    logic load_out_from_in, load_out_from_skid, load_skid;

`ifdef IMM_BRANCH_TARGET_EN
    logic [DATA_WIDTH-1:0] dec_btarget;
    logic [DATA_WIDTH-1:0] out_btarget_reg, skid_btarget_reg;
`endif

    imm_decode #(
        .DATA_WIDTH   (DATA_WIDTH),
        .INSTR_WIDTH  (INSTR_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .TARGET_WIDTH (TARGET_WIDTH)
    ) u_decode (
        .instr   (bus.in_instr),
        .pc      (bus.in_pc),
        .imm     (dec_imm),
        .kind    (dec_kind)
`ifdef IMM_BRANCH_TARGET_EN
        ,.btarget (dec_btarget)
`endif
    );

    assign in_fire = bus.in_valid && in_ready_reg;

    always_comb begin
        state_next         = state_reg;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state_reg)
            BUF_EMPTY: begin
                if (in_fire) begin
                    load_out_from_in = 1'b1;
                    state_next       = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (bus.out_ready) begin
                    if (in_fire) begin
                        load_out_from_in = 1'b1;
                    end else begin
                        state_next = BUF_EMPTY;
                    end
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                // in_ready is low here, so no new entry can arrive.
                if (bus.out_ready) begin
                    load_out_from_skid = 1'b1;
                    state_next         = BUF_ONE;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= BUF_EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_imm_reg   <= '0;
            out_kind_reg  <= IMM_NONE;
            out_pc_reg    <= '0;
            skid_imm_reg  <= '0;
            skid_kind_reg <= IMM_NONE;
            skid_pc_reg   <= '0;
`ifdef IMM_BRANCH_TARGET_EN
            out_btarget_reg  <= '0;
            skid_btarget_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next != BUF_EMPTY);
            in_ready_reg  <= (state_next != BUF_FULL);
            if (load_out_from_in) begin
                out_imm_reg  <= dec_imm;
                out_kind_reg <= dec_kind;
                out_pc_reg   <= bus.in_pc;
`ifdef IMM_BRANCH_TARGET_EN
                out_btarget_reg <= dec_btarget;
`endif
            end else if (load_out_from_skid) begin
                out_imm_reg  <= skid_imm_reg;
                out_kind_reg <= skid_kind_reg;
                out_pc_reg   <= skid_pc_reg;
`ifdef IMM_BRANCH_TARGET_EN
                out_btarget_reg <= skid_btarget_reg;
`endif
            end
            if (load_skid) begin
                skid_imm_reg  <= dec_imm;
                skid_kind_reg <= dec_kind;
                skid_pc_reg   <= bus.in_pc;
`ifdef IMM_BRANCH_TARGET_EN
                skid_btarget_reg <= dec_btarget;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_imm   = out_imm_reg;
    assign bus.out_kind  = out_kind_reg;
    assign bus.out_pc    = out_pc_reg;
`ifdef IMM_BRANCH_TARGET_EN
    assign bus.out_btarget = out_btarget_reg;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table, stalled stream, reset while
// full, and a 32-bit instance. Checks out_btarget when IMM_BRANCH_TARGET_EN.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.DATA_WIDTH(16), .INSTR_WIDTH(16)) bus16 ();
    imm_gen_pipe_if #(.DATA_WIDTH(32), .INSTR_WIDTH(16)) bus32 ();

    imm_gen_pipe #(.DATA_WIDTH(16), .INSTR_WIDTH(16), .OFFSET_WIDTH(8), .TARGET_WIDTH(12))
        dut16 (.clk(clk), .reset(reset), .bus(bus16));
    imm_gen_pipe #(.DATA_WIDTH(32), .INSTR_WIDTH(16), .OFFSET_WIDTH(8), .TARGET_WIDTH(12))
        dut32 (.clk(clk), .reset(reset), .bus(bus32));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] imm;
        logic [2:0]  kind;
        logic [15:0] bt;
    } vec_t;

    vec_t vecs[14];

    // Stalled-stream stimulus and expected outputs.
    logic [15:0] s_instr[4];
    logic [15:0] s_pc[4];
    logic [15:0] s_imm[4];
    logic [2:0]  s_kind[4];
    logic        exp_rdy[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recvd;
        logic stalled_prev;
        logic [15:0] held_imm;
        logic [15:0] held_pc;

        vecs[0]  = '{16'h40FF, 16'h0000, 16'hFFFF, 3'd0, 16'h0000};
        vecs[1]  = '{16'h50FF, 16'h0000, 16'h00FF, 3'd1, 16'h0000};
        vecs[2]  = '{16'h6012, 16'h0000, 16'h1200, 3'd2, 16'h0000};
        vecs[3]  = '{16'h9ABC, 16'h5003, 16'h5ABC, 3'd3, 16'h0000};
        vecs[4]  = '{16'h00FE, 16'h0010, 16'hFFFE, 3'd0, 16'h000F};
        vecs[5]  = '{16'h0080, 16'h0100, 16'hFF80, 3'd0, 16'h0081};
        vecs[6]  = '{16'h3005, 16'h0020, 16'h0005, 3'd0, 16'h0026};
        vecs[7]  = '{16'h707F, 16'h0000, 16'h007F, 3'd0, 16'h0000};
        vecs[8]  = '{16'h8081, 16'h0000, 16'hFF81, 3'd0, 16'h0000};
        vecs[9]  = '{16'hA123, 16'hF000, 16'hF123, 3'd3, 16'h0000};
        vecs[10] = '{16'hB0FF, 16'h1234, 16'h0000, 3'd4, 16'h0000};
        vecs[11] = '{16'hF0FF, 16'h0000, 16'h0000, 3'd4, 16'h0000};
        vecs[12] = '{16'h5080, 16'h0000, 16'h0080, 3'd1, 16'h0000};
        vecs[13] = '{16'h60FF, 16'h0000, 16'hFF00, 3'd2, 16'h0000};

        s_instr = '{16'h4001, 16'h5002, 16'h6003, 16'h9004};
        s_pc    = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        s_imm   = '{16'h0001, 16'h0002, 16'h0300, 16'h0004};
        s_kind  = '{3'd0, 3'd1, 3'd2, 3'd3};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        bus16.in_valid = 1'b0; bus16.in_instr = '0; bus16.in_pc = '0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b1;

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus16.in_ready),  64'd1);
        check("rst_out_kind",  64'(bus16.out_kind),  64'd4);
        check("rst_out_imm",   64'(bus16.out_imm),   64'h0);
        check("rst_out_pc",    64'(bus16.out_pc),    64'h0);
`ifdef IMM_BRANCH_TARGET_EN
        check("rst_btarget",   64'(bus16.out_btarget), 64'h0);
`endif

        // Decode table, one transaction at a time.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus16.in_valid  = 1'b1;
            bus16.in_instr  = vecs[i].instr;
            bus16.in_pc     = vecs[i].pc;
            bus16.out_ready = 1'b1;
            @(negedge clk);
            bus16.in_valid = 1'b0;
            $display("vec %0d: instr=0x%04h pc=0x%04h -> imm=0x%04h kind=%0d", i,
                     vecs[i].instr, vecs[i].pc, bus16.out_imm, bus16.out_kind);
            check($sformatf("vec%0d_valid", i), 64'(bus16.out_valid), 64'd1);
            check($sformatf("vec%0d_imm", i),   64'(bus16.out_imm),   64'(vecs[i].imm));
            check($sformatf("vec%0d_kind", i),  64'(bus16.out_kind),  64'(vecs[i].kind));
            check($sformatf("vec%0d_pc", i),    64'(bus16.out_pc),    64'(vecs[i].pc));
`ifdef IMM_BRANCH_TARGET_EN
            check($sformatf("vec%0d_bt", i),    64'(bus16.out_btarget), 64'(vecs[i].bt));
`endif
        end
        @(negedge clk);
        check("drain_empty", 64'(bus16.out_valid), 64'd0);

        // Back-to-back stream of 4 with out_ready low in cycles 2-4.
        sent = 0;
        recvd = 0;
        stalled_prev = 1'b0;
        held_imm = '0;
        held_pc = '0;
        for (int c = 0; c < 20 && recvd < 4; c++) begin
            @(negedge clk);
            bus16.out_ready = !(c >= 2 && c <= 4);
            bus16.in_valid  = (sent < 4);
            if (sent < 4) begin
                bus16.in_instr = s_instr[sent];
                bus16.in_pc    = s_pc[sent];
            end
            if (c < 8)
                check($sformatf("stream_c%0d_in_ready", c), 64'(bus16.in_ready), 64'(exp_rdy[c]));
            if (stalled_prev) begin
                check($sformatf("stream_c%0d_hold_imm", c), 64'(bus16.out_imm), 64'(held_imm));
                check($sformatf("stream_c%0d_hold_pc", c),  64'(bus16.out_pc),  64'(held_pc));
            end
            stalled_prev = bus16.out_valid && !bus16.out_ready;
            held_imm = bus16.out_imm;
            held_pc  = bus16.out_pc;
            if (bus16.out_valid && bus16.out_ready) begin
                $display("stream out %0d: imm=0x%04h kind=%0d pc=0x%04h", recvd,
                         bus16.out_imm, bus16.out_kind, bus16.out_pc);
                check($sformatf("stream%0d_imm", recvd),  64'(bus16.out_imm),  64'(s_imm[recvd]));
                check($sformatf("stream%0d_kind", recvd), 64'(bus16.out_kind), 64'(s_kind[recvd]));
                check($sformatf("stream%0d_pc", recvd),   64'(bus16.out_pc),   64'(s_pc[recvd]));
                recvd++;
            end
            if (bus16.in_valid && bus16.in_ready)
                sent++;
        end
        check("stream_count", 64'(recvd), 64'd4);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        check("stream_no_dup", 64'(bus16.out_valid), 64'd0);

        // Fill output and skid, then reset while full.
        @(negedge clk);
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.in_instr  = 16'h4011;
        bus16.in_pc     = 16'h0200;
        @(negedge clk);
        bus16.in_instr  = 16'h4022;
        bus16.in_pc     = 16'h0201;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        check("full_in_ready",  64'(bus16.in_ready),  64'd0);
        check("full_out_valid", 64'(bus16.out_valid), 64'd1);
        check("full_out_imm",   64'(bus16.out_imm),   64'h0011);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus16.out_ready = 1'b1;
        $display("reset while full: out_valid=%0d in_ready=%0d", bus16.out_valid, bus16.in_ready);
        check("frst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("frst_in_ready",  64'(bus16.in_ready),  64'd1);
        check("frst_out_kind",  64'(bus16.out_kind),  64'd4);
        check("frst_out_imm",   64'(bus16.out_imm),   64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("frst_no_stale%0d", k), 64'(bus16.out_valid), 64'd0);
        end

        // 32-bit datapath instance.
        @(negedge clk);
        bus32.in_valid = 1'b1;
        bus32.in_instr = 16'h00FE;
        bus32.in_pc    = 32'h0000_0010;
        @(negedge clk);
        bus32.in_instr = 16'h9ABC;
        bus32.in_pc    = 32'h1234_5003;
        $display("w32 BNE: imm=0x%08h kind=%0d", bus32.out_imm, bus32.out_kind);
        check("w32_bne_valid", 64'(bus32.out_valid), 64'd1);
        check("w32_bne_imm",   64'(bus32.out_imm),   64'hFFFF_FFFE);
        check("w32_bne_kind",  64'(bus32.out_kind),  64'd0);
`ifdef IMM_BRANCH_TARGET_EN
        check("w32_bne_bt",    64'(bus32.out_btarget), 64'h0000_000F);
`endif
        @(negedge clk);
        bus32.in_instr = 16'h6012;
        bus32.in_pc    = 32'h0000_0000;
        $display("w32 JMP: imm=0x%08h kind=%0d", bus32.out_imm, bus32.out_kind);
        check("w32_jmp_imm",  64'(bus32.out_imm),  64'h1234_5ABC);
        check("w32_jmp_kind", 64'(bus32.out_kind), 64'd3);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        $display("w32 LHI: imm=0x%08h kind=%0d", bus32.out_imm, bus32.out_kind);
        check("w32_lhi_imm",  64'(bus32.out_imm),  64'h0000_1200);
        check("w32_lhi_kind", 64'(bus32.out_kind), 64'd2);
        @(negedge clk);
        check("w32_drain", 64'(bus32.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
